// File: rtl/in1_conditioner.sv
// in1_conditioner: synchronises, debounces and edge-detects a raw level feeding the detector In1.
// Define IN1_CONDITIONER_GLITCH_CNT_EN to add the GLITCH_CLR/GLITCH_CNT debug counter.
module in1_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned GLITCH_W        = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                DIN,
  input  logic                EN,
  output logic                DOUT,
  output logic                RISE,
  output logic                FALL
`ifdef IN1_CONDITIONER_GLITCH_CNT_EN
  ,
  input  logic                GLITCH_CLR,
  output logic [GLITCH_W-1:0] GLITCH_CNT
`endif
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1 || (64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt
    $error("DEBOUNCE_CYCLES must be >= 1 and below 2**CNT_W");
  end
  if (GLITCH_W < 1) begin : g_bad_glitch
    $error("GLITCH_W must be at least 1");
  end

  localparam logic [CNT_W-1:0] DbLast = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic {StStable, StCheck} state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_lvl;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                   dout_q, dout_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   commit;

  // Synchroniser runs every cycle regardless of EN.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], DIN};
    end
  end

  assign s_lvl   = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    commit  = 1'b0;
    if (EN) begin
      unique case (state_q)
        StStable: begin
          if (s_lvl != dout_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              commit = 1'b1;
            end else begin
              state_d = StCheck;
              cnt_d   = CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        StCheck: begin
          if (s_lvl != dout_q) begin
            if (cnt_inc == DbLast) begin
              commit = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            // Level fell back before the window filled: drop the candidate.
            state_d = StStable;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StStable;
          cnt_d   = '0;
        end
      endcase
    end
    if (commit) begin
      dout_d  = s_lvl;
      cnt_d   = '0;
      state_d = StStable;
      rise_d  = s_lvl;
      fall_d  = ~s_lvl;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StStable;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign DOUT = dout_q;
  assign RISE = rise_q;
  assign FALL = fall_q;

`ifdef IN1_CONDITIONER_GLITCH_CNT_EN
  logic [GLITCH_W-1:0] glitch_q;
  logic                glitch_hit;

  assign glitch_hit = EN && (state_q == StCheck) && (s_lvl == dout_q);

  // Clear wins over a same-cycle abort; count saturates at all-ones.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      glitch_q <= '0;
    end else if (GLITCH_CLR) begin
      glitch_q <= '0;
    end else if (glitch_hit && (glitch_q != '1)) begin
      glitch_q <= glitch_q + GLITCH_W'(1);
    end
  end

  assign GLITCH_CNT = glitch_q;
`endif

endmodule

// File: tb/tb_in1_conditioner.sv
// Scoreboard bench for in1_conditioner: expected RISE/FALL pulses are queued with their edge number.
// Glitch-count checks are active only when IN1_CONDITIONER_GLITCH_CNT_EN is defined.
module tb_in1_conditioner;

  localparam int unsigned GW = 4;

  logic CLK, RST, DIN, EN, DOUT, RISE, FALL;
`ifdef IN1_CONDITIONER_GLITCH_CNT_EN
  logic          GLITCH_CLR;
  logic [GW-1:0] GLITCH_CNT;
`endif

  typedef struct packed {
    logic rise;
    int   at;
  } ev_t;

  ev_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  edge_no = 0;
  bit  sparse  = 1'b0;

  in1_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (4),
    .GLITCH_W       (GW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .DIN       (DIN),
    .EN        (EN),
    .DOUT      (DOUT),
    .RISE      (RISE),
    .FALL      (FALL)
`ifdef IN1_CONDITIONER_GLITCH_CNT_EN
    ,
    .GLITCH_CLR(GLITCH_CLR),
    .GLITCH_CNT(GLITCH_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_no <= edge_no + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  task automatic push(input logic r, input int at);
    ev_t e;
    e.rise = r;
    e.at   = at;
    sb.push_back(e);
  endtask

  // Advance to the next falling edge(s); EN for the coming rising edge is set here.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      EN = sparse ? (((edge_no + 1) % 4) == 0) : 1'b1;
    end
  endtask

  task automatic goto(input int e);
    while (edge_no < e) step(1);
  endtask

  task automatic monitor();
    ev_t e;
    forever begin
      @(negedge CLK);
      if (RISE || FALL) begin
        n_tests++;
        if (RISE && FALL) begin
          n_fail++;
          $display("FAIL pulse_both: RISE and FALL both high at edge %0d, want one", edge_no);
        end else if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL pulse_unexpected: rise=%0d fall=%0d at edge %0d, want no pulse",
                   RISE, FALL, edge_no);
        end else begin
          e = sb.pop_front();
          if (e.rise !== RISE || e.at != edge_no) begin
            n_fail++;
            $display("FAIL pulse_match: rise=%0d at edge %0d, want rise=%0d at edge %0d",
                     RISE, edge_no, e.rise, e.at);
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k;
    int r;
    RST = 1'b0;
    DIN = 1'b1;
    EN  = 1'b1;
`ifdef IN1_CONDITIONER_GLITCH_CNT_EN
    GLITCH_CLR = 1'b0;
`endif
    fork
      monitor();
    join_none

    // Reset state
    step(3);
    check("reset_dout", DOUT, 0);
    check("reset_rise", RISE, 0);
    check("reset_fall", FALL, 0);
`ifdef IN1_CONDITIONER_GLITCH_CNT_EN
    check("reset_glitch", GLITCH_CNT, 0);
`endif

    // 1: release with DIN=1 -> rise on edge 6 after release
    k   = edge_no;
    RST = 1'b1;
    push(1'b1, k + 6);
    goto(k + 5);
    check("t1_dout_before", DOUT, 0);
    goto(k + 6);
    check("t1_dout_after", DOUT, 1);
    goto(k + 7);
    check("t1_rise_one_cycle", RISE, 0);

    // 2: DIN low and held -> fall 6 edges later, then quiet
    step(2);
    k   = edge_no;
    DIN = 1'b0;
    push(1'b0, k + 6);
    goto(k + 5);
    check("t2_dout_before", DOUT, 1);
    goto(k + 6);
    check("t2_dout_after", DOUT, 0);
    step(20);
    check("t2_dout_quiet", DOUT, 0);

    // 3: 3-cycle high pulse is rejected as a glitch
    k   = edge_no;
    DIN = 1'b1;
    goto(k + 3);
    DIN = 1'b0;
    goto(k + 10);
    check("t3_dout", DOUT, 0);
`ifdef IN1_CONDITIONER_GLITCH_CNT_EN
    check("t3_glitch", GLITCH_CNT, 1);
`endif

    // 4: EN on every 4th edge -> rise on 4th EN edge after S=1
    while ((edge_no % 4) != 0) step(1);
    sparse = 1'b1;
    EN     = 1'b0;
    k      = edge_no;
    DIN    = 1'b1;
    push(1'b1, k + 16);
    goto(k + 15);
    check("t4_dout_before", DOUT, 0);
    goto(k + 16);
    check("t4_dout_after", DOUT, 1);
    sparse = 1'b0;
    EN     = 1'b1;

    // 5: reset with counter at 3 drops the pending fall; fresh latency afterwards
    step(4);
    k   = edge_no;
    DIN = 1'b0;
    goto(k + 5);
    RST = 1'b0;
    #1;
    check("t5_reset_dout", DOUT, 0);
    check("t5_reset_rise", RISE, 0);
    check("t5_reset_fall", FALL, 0);
    step(1);
    r   = edge_no;
    RST = 1'b1;
    DIN = 1'b1;
    push(1'b1, r + 6);
    goto(r + 5);
    check("t5_dout_before", DOUT, 0);
    goto(r + 6);
    check("t5_dout_after", DOUT, 1);

    // 6: 20 two-cycle low glitches while DOUT=1, then a cleared 21st
    step(4);
    for (int i = 0; i < 20; i++) begin
      k   = edge_no;
      DIN = 1'b0;
      goto(k + 2);
      DIN = 1'b1;
      goto(k + 8);
`ifdef IN1_CONDITIONER_GLITCH_CNT_EN
      if (i == 0) check("t6_glitch_first", GLITCH_CNT, 1);
      if (i == 14) check("t6_glitch_fifteen", GLITCH_CNT, 15);
`endif
    end
    check("t6_dout_held", DOUT, 1);
`ifdef IN1_CONDITIONER_GLITCH_CNT_EN
    check("t6_glitch_sat", GLITCH_CNT, 15);
`endif
    k   = edge_no;
    DIN = 1'b0;
    goto(k + 2);
    DIN = 1'b1;
    goto(k + 4);
`ifdef IN1_CONDITIONER_GLITCH_CNT_EN
    GLITCH_CLR = 1'b1;
`endif
    goto(k + 5);
`ifdef IN1_CONDITIONER_GLITCH_CNT_EN
    GLITCH_CLR = 1'b0;
    check("t6_glitch_clr", GLITCH_CNT, 0);
`endif
    goto(k + 8);
`ifdef IN1_CONDITIONER_GLITCH_CNT_EN
    check("t6_glitch_clr_hold", GLITCH_CNT, 0);
`endif
    check("t6_dout_final", DOUT, 1);

    step(10);
    check("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
